// File: rtl/tictac_pkg.sv
// rtl/tictac_pkg.sv - shared cell codes, line table, static order and FSM states for the move generator
package tictac_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  localparam logic [3:0] LINE_TABLE [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  localparam logic [3:0] STATIC_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN_WIN,
    ST_SCAN_BLOCK,
    ST_STATIC,
    ST_ISSUE
  } state_t;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] n);
    return b[{n, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/computer_move_generator_if.sv
// rtl/computer_move_generator_if.sv - trigger/board inputs and move outputs of the move generator
interface computer_move_generator_if;
  logic        start;
  logic [17:0] board;
  logic [3:0]  computer_position;
  logic        pc;
  logic        busy;
  logic        no_move;

  modport master (output start, board, input computer_position, pc, busy, no_move);
  modport slave  (input start, board, output computer_position, pc, busy, no_move);
endinterface

// File: rtl/line_evaluator.sv
// rtl/line_evaluator.sv - flags a line holding two marks and one empty cell, reports the empty cell offset
module line_evaluator
  import tictac_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] offset
);

  always_comb begin
    hit    = 1'b0;
    offset = 2'd0;
    if (cell_a == mark && cell_b == mark && cell_c == CELL_EMPTY) begin
      hit    = 1'b1;
      offset = 2'd2;
    end else if (cell_a == mark && cell_c == mark && cell_b == CELL_EMPTY) begin
      hit    = 1'b1;
      offset = 2'd1;
    end else if (cell_b == mark && cell_c == mark && cell_a == CELL_EMPTY) begin
      hit    = 1'b1;
      offset = 2'd0;
    end
  end

endmodule

// File: rtl/computer_move_generator.sv
// rtl/computer_move_generator.sv - tic-tac-toe opponent: snapshot board, scan win/block lines, fall back to static order
module computer_move_generator
  import tictac_pkg::*;
#(
  parameter int PC_HOLD      = 1,
  parameter bit SKIP_TACTICS = 1'b0
) (
  input logic                        clock,
  input logic                        reset,
  computer_move_generator_if.slave   bus
);

  state_t      state_q, state_d;
  logic [17:0] snap_q, snap_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  pos_q, pos_d;
  logic        pc_q, pc_d;
  logic        busy_q, busy_d;
  logic        no_move_q, no_move_d;

  logic        hit;
  logic [1:0]  offset;
  logic [1:0]  mark;
  logic [3:0]  target;
  logic        static_found;
  logic [3:0]  static_pos;

  assign mark = (state_q == ST_SCAN_BLOCK) ? CELL_PLAYER : CELL_COMPUTER;

  line_evaluator u_line_evaluator (
    .cell_a (cell_at(snap_q, LINE_TABLE[idx_q][0])),
    .cell_b (cell_at(snap_q, LINE_TABLE[idx_q][1])),
    .cell_c (cell_at(snap_q, LINE_TABLE[idx_q][2])),
    .mark   (mark),
    .hit    (hit),
    .offset (offset)
  );

  always_comb begin
    case (offset)
      2'd0:    target = LINE_TABLE[idx_q][0];
      2'd1:    target = LINE_TABLE[idx_q][1];
      default: target = LINE_TABLE[idx_q][2];
    endcase
  end

  // Walk the preference order backwards so the earliest empty cell is the one left standing.
  always_comb begin
    static_found = 1'b0;
    static_pos   = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (cell_at(snap_q, STATIC_ORDER[i]) == CELL_EMPTY) begin
        static_found = 1'b1;
        static_pos   = STATIC_ORDER[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    pos_d     = pos_q;
    pc_d      = 1'b0;
    no_move_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        snap_d  = bus.board;
        idx_d   = 3'd0;
        state_d = SKIP_TACTICS ? ST_STATIC : ST_SCAN_WIN;
      end
      ST_SCAN_WIN, ST_SCAN_BLOCK: begin
        if (hit) begin
          pos_d   = target;
          pc_d    = 1'b1;
          hold_d  = 4'd1;
          state_d = ST_ISSUE;
        end else if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          state_d = (state_q == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_STATIC;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_STATIC: begin
        if (static_found) begin
          pos_d   = static_pos;
          pc_d    = 1'b1;
          hold_d  = 4'd1;
          state_d = ST_ISSUE;
        end else begin
          no_move_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hold_q == 4'(PC_HOLD)) begin
          state_d = ST_IDLE;
        end else begin
          pc_d   = 1'b1;
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      pos_q     <= '0;
      pc_q      <= 1'b0;
      busy_q    <= 1'b0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      pos_q     <= pos_d;
      pc_q      <= pc_d;
      busy_q    <= busy_d;
      no_move_q <= no_move_d;
    end
  end

  assign bus.computer_position = pos_q;
  assign bus.pc                = pc_q;
  assign bus.busy              = busy_q;
  assign bus.no_move           = no_move_q;

endmodule

// File: tb/tb_computer_move_generator.sv
// tb/tb_computer_move_generator.sv - randomized and directed checks of the move generator against a rule-level model
module tb_computer_move_generator;

  localparam int PC_HOLD = 3;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int order [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  computer_move_generator_if bus ();

  computer_move_generator #(.PC_HOLD(PC_HOLD), .SKIP_TACTICS(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] bd(input int c0, input int c1, input int c2, input int c3,
                                     input int c4, input int c5, input int c6, input int c7,
                                     input int c8);
    return {2'(c8), 2'(c7), 2'(c6), 2'(c5), 2'(c4), 2'(c3), 2'(c2), 2'(c1), 2'(c0)};
  endfunction

  // Rule-level opponent: count marks per line, win pass then block pass, then preference order.
  function automatic void model(input logic [17:0] b, output bit nm, output int pos, output int lat);
    int c [9];
    int marks, empties, gap, want;
    for (int i = 0; i < 9; i++) c[i] = int'(b[2*i +: 2]);
    nm  = 1'b0;
    pos = 0;
    lat = 18;
    for (int pass = 0; pass < 2; pass++) begin
      want = (pass == 0) ? 2 : 1;
      for (int k = 0; k < 8; k++) begin
        marks = 0; empties = 0; gap = 0;
        for (int j = 0; j < 3; j++) begin
          if (c[lines[k][j]] == want) marks++;
          else if (c[lines[k][j]] == 0) begin
            empties++;
            gap = lines[k][j];
          end
        end
        if (marks == 2 && empties == 1) begin
          pos = gap;
          lat = (pass == 0) ? k + 2 : k + 10;
          return;
        end
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (c[order[i]] == 0) begin
        pos = order[i];
        return;
      end
    end
    nm = 1'b1;
  endfunction

  task automatic run_move(input logic [17:0] b, input string tag, input int poke_at);
    bit exp_nm;
    int exp_pos, exp_lat, lat, high, busy_ok, extra;
    model(b, exp_nm, exp_pos, exp_lat);
    @(negedge clock);
    bus.board = b;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    lat = 1;
    bus.board = 18'($urandom());
    busy_ok = 1;
    while (!bus.pc && !bus.no_move && lat < 40) begin
      if (!bus.busy) busy_ok = 0;
      bus.start = (lat == poke_at);
      @(posedge clock); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_during_scan"}, busy_ok, 1);
    chk({tag, ".no_move"}, int'(bus.no_move), int'(exp_nm));
    if (!exp_nm) begin
      chk({tag, ".position"}, int'(bus.computer_position), exp_pos);
      high = 0;
      while (bus.pc && high < 20) begin
        high++;
        @(posedge clock); #1;
      end
      chk({tag, ".pc_width"}, high, PC_HOLD);
    end else begin
      chk({tag, ".pc_on_no_move"}, int'(bus.pc), 0);
      @(posedge clock); #1;
      chk({tag, ".no_move_width"}, int'(bus.no_move), 0);
    end
    chk({tag, ".idle_after"}, int'(bus.busy), 0);
    if (poke_at > 0) begin
      extra = 0;
      repeat (25) begin
        @(posedge clock); #1;
        if (bus.pc || bus.busy) extra++;
      end
      chk({tag, ".no_second_move"}, extra, 0);
    end
  endtask

  initial begin
    logic [17:0] rb;
    int v;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.board = '0;
    #12;
    chk("reset.position", int'(bus.computer_position), 0);
    chk("reset.pc", int'(bus.pc), 0);
    chk("reset.busy", int'(bus.busy), 0);
    chk("reset.no_move", int'(bus.no_move), 0);
    @(negedge clock);
    reset = 1'b0;

    run_move(bd(0,0,0,0,0,0,0,0,0), "empty_board", 0);
    run_move(bd(2,2,0,1,0,0,0,0,0), "win_line0", 0);
    run_move(bd(1,0,0,0,1,2,0,0,0), "block_line6", 0);
    run_move(bd(2,2,0,1,1,0,0,0,0), "win_over_block", 0);
    run_move(bd(1,2,1,2,1,2,2,1,2), "full_board", 0);
    run_move(bd(3,3,3,3,3,3,3,3,3), "all_occupied", 0);
    run_move(bd(0,0,0,0,0,0,0,0,0), "start_while_busy", 5);

    run_move(bd(1,0,0,0,1,2,0,0,0), "pre_reset", 0);
    @(negedge clock);
    bus.board = '0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    chk("mid_block.busy", int'(bus.busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset.position", int'(bus.computer_position), 0);
    chk("async_reset.busy", int'(bus.busy), 0);
    chk("async_reset.pc", int'(bus.pc), 0);
    chk("async_reset.no_move", int'(bus.no_move), 0);
    @(negedge clock);
    reset = 1'b0;
    run_move(bd(1,1,0,0,0,0,0,0,0), "after_reset", 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 9; i++) begin
        v = $urandom_range(0, 9);
        rb[2*i +: 2] = (v < 4) ? 2'b00 : (v < 7) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
      end
      run_move(rb, $sformatf("random%0d", t), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
